// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit between EXU and WBU.
// Accepts one instruction at a time. Memory ops go out as a single word
// request on the memory port. The load result is aligned and extended on the
// response. Everything else is forwarded after a single cycle.
module ysyx_25040109_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_wen,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic              out_err
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_wen_q, req_wen_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_wen_q, out_wen_d;
    logic              out_err_q, out_err_d;

    logic              is_load, is_store, f3_ok, aligned;
    logic [1:0]        off;
    logic [DATA_W-1:0] st_wdata, ld_shift, ld_data;
    logic [3:0]        st_wstrb;

    // Decode the incoming instruction: funct3 legality, alignment, store lanes
    always_comb begin
        is_load  = (in_opcode == OP_LOAD);
        is_store = (in_opcode == OP_STORE);
        off      = in_result[1:0];
        f3_ok    = 1'b0;
        if (is_load)
            f3_ok = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (is_store)
            f3_ok = in_funct3 inside {3'b000, 3'b001, 3'b010};
        // funct3[1:0] is the access size for every legal encoding
        case (in_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        case (in_funct3[1:0])
            2'b00: begin
                st_wdata = {4{in_rs2[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{in_rs2[15:0]}};
                st_wstrb = 4'b0011 << off;
            end
            default: begin
                st_wdata = in_rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Align the raw response word to the addressed byte and extend it
    always_comb begin
        ld_shift = resp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Next-state and datapath register updates for the IDLE/REQ/WAIT/DONE flow
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    funct3_d    = in_funct3;
                    off_d       = off;
                    out_rd_d    = in_rd;
                    req_addr_d  = '0;
                    req_wen_d   = 1'b0;
                    req_wdata_d = '0;
                    req_wstrb_d = '0;
                    if ((is_load || is_store) && f3_ok && aligned) begin
                        req_addr_d = {in_result[ADDR_W-1:2], 2'b00};
                        req_wen_d  = is_store;
                        if (is_store) begin
                            req_wdata_d = st_wdata;
                            req_wstrb_d = st_wstrb;
                        end
                        out_data_d = '0;
                        out_wen_d  = is_load & in_wen;
                        out_err_d  = 1'b0;
                        state_d    = REQ;
                    end else if (is_load || is_store) begin
                        // Bad access: report it without touching memory
                        out_data_d = '0;
                        out_wen_d  = 1'b0;
                        out_err_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        out_data_d = in_result;
                        out_wen_d  = in_wen;
                        out_err_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            REQ: begin
                if (req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (resp_valid) begin
                    out_data_d = req_wen_q ? '0 : ld_data;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign req_valid = (state_q == REQ);
    assign out_valid = (state_q == DONE);
    assign req_addr  = req_addr_q;
    assign req_wen   = req_wen_q;
    assign req_wdata = req_wdata_q;
    assign req_wstrb = req_wstrb_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_wen   = out_wen_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Bench for ysyx_25040109_lsu: directed vector table, reset corner cases and
// randomized transactions checked against an arithmetic reference model.
module tb_ysyx_25040109_lsu;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_result, in_rs2;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen, out_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_st;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data;
        logic        exp_wen;
        logic        exp_err;
        int          rs;
        int          rdl;
        int          os;
    } vec_t;

    vec_t tbl[15];

    ysyx_25040109_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_result(in_result), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_wen(in_wen),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd),
        .out_wen(out_wen), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: derive the expected result from the ISA rules with arithmetic
    function automatic vec_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] res, input logic [31:0] rs2,
                                   input logic [4:0] rd, input logic wen,
                                   input logic [31:0] rdata);
        vec_t v;
        int off, size;
        bit legal, sgn;
        longint unsigned raw, mask;
        v.op = op; v.f3 = f3; v.res = res; v.rs2 = rs2; v.rd = rd; v.wen = wen;
        v.rdata = rdata; v.exp_req = 0; v.exp_st = 0; v.exp_addr = 0;
        v.exp_wdata = 0; v.exp_wstrb = 0; v.exp_data = 0; v.exp_wen = 0;
        v.exp_err = 0; v.rs = 0; v.rdl = 0; v.os = 0;
        off = int'(res % 4);
        size = 0; legal = 0; sgn = 0;
        if (op == OP_LOAD) begin
            case (f3)
                3'd0: begin size = 1; sgn = 1; legal = 1; end
                3'd1: begin size = 2; sgn = 1; legal = 1; end
                3'd2: begin size = 4; legal = 1; end
                3'd4: begin size = 1; legal = 1; end
                3'd5: begin size = 2; legal = 1; end
                default: legal = 0;
            endcase
        end else if (op == OP_STORE) begin
            case (f3)
                3'd0: begin size = 1; legal = 1; end
                3'd1: begin size = 2; legal = 1; end
                3'd2: begin size = 4; legal = 1; end
                default: legal = 0;
            endcase
        end
        if (op != OP_LOAD && op != OP_STORE) begin
            v.exp_data = res;
            v.exp_wen = wen;
        end else if (!legal || (off % size) != 0) begin
            v.exp_err = 1;
        end else begin
            v.exp_req = 1;
            v.exp_addr = res - 32'(off);
            mask = (64'd1 << (8 * size)) - 1;
            if (op == OP_STORE) begin
                v.exp_st = 1;
                v.exp_wstrb = 4'(((1 << size) - 1) << off);
                if (size == 1) v.exp_wdata = 32'(longint'(rs2 % 256) * 64'h01010101);
                else if (size == 2) v.exp_wdata = 32'(longint'(rs2 % 65536) * 64'h00010001);
                else v.exp_wdata = rs2;
            end else begin
                raw = (longint'(rdata) >> (8 * off)) & mask;
                if (sgn && raw >= (mask + 1) / 2) raw = raw - (mask + 1);
                v.exp_data = 32'(raw);
                v.exp_wen = wen;
            end
        end
        return v;
    endfunction

    // Drive one instruction through and act as memory and WBU around it
    task automatic run_txn(input vec_t v);
        int cyc, req_cnt, resp_cnt, out_cnt, first_req, first_out;
        bit hs_pending, waiting, done, req_stable, out_stable, busy_ok;
        logic [31:0] a0, d0, od;
        logic [3:0] s0;
        logic w0, ow, oe;
        logic [4:0] ordv;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_opcode = v.op; in_funct3 = v.f3; in_result = v.res; in_rs2 = v.rs2;
        in_rd = v.rd; in_wen = v.wen; resp_rdata = v.rdata;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0; req_cnt = 0; resp_cnt = 0; out_cnt = 0;
        first_req = -1; first_out = -1;
        hs_pending = 0; waiting = 0; done = 0;
        req_stable = 1; out_stable = 1; busy_ok = 1;
        a0 = 0; d0 = 0; s0 = 0; w0 = 0; od = 0; ow = 0; oe = 0; ordv = 0;
        while (!done && cyc < 100) begin
            if (in_ready) busy_ok = 0;
            resp_valid = 1'b0;
            if (hs_pending) begin waiting = 1; hs_pending = 0; end
            if (waiting) begin
                resp_valid = (resp_cnt >= v.rdl);
                resp_cnt++;
                if (resp_valid) waiting = 0;
            end
            if (req_valid) begin
                if (first_req < 0) begin
                    first_req = cyc;
                    a0 = req_addr; d0 = req_wdata; s0 = req_wstrb; w0 = req_wen;
                    chk("req_addr", req_addr, v.exp_addr);
                    chk("req_wen", 32'(req_wen), 32'(v.exp_st));
                    chk("req_wstrb", 32'(req_wstrb), 32'(v.exp_wstrb));
                    if (v.exp_st) chk("req_wdata", req_wdata, v.exp_wdata);
                end else if (req_addr !== a0 || req_wdata !== d0 ||
                             req_wstrb !== s0 || req_wen !== w0) begin
                    req_stable = 0;
                end
                req_ready = (req_cnt >= v.rs);
                req_cnt++;
                if (req_ready) hs_pending = 1;
            end else begin
                req_ready = 1'b0;
            end
            if (out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    od = out_data; ow = out_wen; oe = out_err; ordv = out_rd;
                    chk("out_data", out_data, v.exp_data);
                    chk("out_rd", 32'(out_rd), 32'(v.rd));
                    chk("out_wen", 32'(out_wen), 32'(v.exp_wen));
                    chk("out_err", 32'(out_err), 32'(v.exp_err));
                end else if (out_data !== od || out_wen !== ow ||
                             out_err !== oe || out_rd !== ordv) begin
                    out_stable = 0;
                end
                out_ready = (out_cnt >= v.os);
                out_cnt++;
                if (out_ready) done = 1;
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
        chk("out_handshake", 32'(done), 32'd1);
        chk("req_issued_cycle", 32'(first_req), v.exp_req ? 32'd0 : 32'hFFFF_FFFF);
        chk("out_latency", 32'(first_out), v.exp_req ? 32'(v.rs + v.rdl + 2) : 32'd0);
        chk("req_stable", 32'(req_stable), 32'd1);
        chk("out_stable", 32'(out_stable), 32'd1);
        chk("in_ready_busy_low", 32'(busy_ok), 32'd1);
        chk("single_out_xfer", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    // Accept a legal load and let it reach REQ
    task automatic start_load(input logic [31:0] addr);
        in_opcode = OP_LOAD; in_funct3 = 3'd2; in_result = addr;
        in_rs2 = 0; in_rd = 5'd6; in_wen = 1'b1; resp_rdata = 32'h5555_AAAA;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; in_valid = 0; in_opcode = 0; in_funct3 = 0; in_result = 0;
        in_rs2 = 0; in_rd = 0; in_wen = 0; req_ready = 0; resp_valid = 0;
        resp_rdata = 0; out_ready = 0;

        //        op       f3    res            rs2            rd    wen   rdata          req st addr           wdata          wstrb  data           wen err rs rdl os
        tbl[0]  = '{7'h13, 3'd0, 32'h0000_1234, 32'h0,         5'd5, 1'b1, 32'h0,         1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'h0000_1234, 1'b1,1'b0, 0,0,0};
        tbl[1]  = '{7'h03, 3'd0, 32'h8000_0003, 32'h0,         5'd7, 1'b1, 32'h80FF_7F01, 1'b1,1'b0,32'h8000_0000,32'h0,     4'h0, 32'hFFFF_FF80, 1'b1,1'b0, 0,0,0};
        tbl[2]  = '{7'h03, 3'd4, 32'h8000_0003, 32'h0,         5'd7, 1'b1, 32'h80FF_7F01, 1'b1,1'b0,32'h8000_0000,32'h0,     4'h0, 32'h0000_0080, 1'b1,1'b0, 0,0,0};
        tbl[3]  = '{7'h23, 3'd1, 32'h8000_0102, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0,         1'b1,1'b1,32'h8000_0100,32'hBEEF_BEEF,4'hC,32'h0,        1'b0,1'b0, 0,0,0};
        tbl[4]  = '{7'h03, 3'd2, 32'h8000_0001, 32'h0,         5'd3, 1'b1, 32'h1234_5678, 1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'h0,         1'b0,1'b1, 0,0,0};
        tbl[5]  = '{7'h03, 3'd1, 32'h8000_0002, 32'h0,         5'd4, 1'b1, 32'h80FF_7F01, 1'b1,1'b0,32'h8000_0000,32'h0,     4'h0, 32'hFFFF_80FF, 1'b1,1'b0, 1,1,1};
        tbl[6]  = '{7'h03, 3'd5, 32'h8000_0002, 32'h0,         5'd4, 1'b1, 32'h80FF_7F01, 1'b1,1'b0,32'h8000_0000,32'h0,     4'h0, 32'h0000_80FF, 1'b1,1'b0, 0,2,0};
        tbl[7]  = '{7'h03, 3'd2, 32'h8000_0010, 32'h0,         5'd8, 1'b1, 32'h1234_5678, 1'b1,1'b0,32'h8000_0010,32'h0,     4'h0, 32'h1234_5678, 1'b1,1'b0, 0,0,0};
        tbl[8]  = '{7'h23, 3'd0, 32'h8000_0001, 32'h0000_00A5, 5'd2, 1'b1, 32'h0,         1'b1,1'b1,32'h8000_0000,32'hA5A5_A5A5,4'h2,32'h0,        1'b0,1'b0, 0,1,0};
        tbl[9]  = '{7'h23, 3'd2, 32'h8000_0004, 32'hCAFE_BABE, 5'd1, 1'b0, 32'h0,         1'b1,1'b1,32'h8000_0004,32'hCAFE_BABE,4'hF,32'h0,        1'b0,1'b0, 2,0,1};
        tbl[10] = '{7'h03, 3'd2, 32'h8000_0020, 32'h0,         5'd10,1'b1, 32'h0BAD_F00D, 1'b1,1'b0,32'h8000_0020,32'h0,     4'h0, 32'h0BAD_F00D, 1'b1,1'b0, 3,2,2};
        tbl[11] = '{7'h03, 3'd1, 32'h8000_0001, 32'h0,         5'd11,1'b1, 32'h0,         1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'h0,         1'b0,1'b1, 0,0,0};
        tbl[12] = '{7'h03, 3'd3, 32'h8000_0000, 32'h0,         5'd12,1'b1, 32'h0,         1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'h0,         1'b0,1'b1, 0,0,0};
        tbl[13] = '{7'h23, 3'd4, 32'h8000_0000, 32'h1,         5'd13,1'b1, 32'h0,         1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'h0,         1'b0,1'b1, 0,0,1};
        tbl[14] = '{7'h37, 3'd0, 32'hABCD_E000, 32'h0,         5'd12,1'b0, 32'h0,         1'b0,1'b0,32'h0,     32'h0,         4'h0, 32'hABCD_E000, 1'b0,1'b0, 0,0,2};

        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_wen", 32'(req_wen), 32'd0);
        chk("rst_req_wstrb", 32'(req_wstrb), 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        chk("rst_req_wdata", req_wdata, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_wen", 32'(out_wen), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);

        // A response with nothing outstanding must be ignored
        resp_valid = 1'b1;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        chk("idle_resp_out_valid", 32'(out_valid), 32'd0);
        chk("idle_resp_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 15; i++) run_txn(tbl[i]);

        // Reset while the request is outstanding
        start_load(32'h8000_0040);
        chk("req_pending", 32'(req_valid), 32'd1);
        pulse_rst;
        chk("rst_req_drop", 32'(req_valid), 32'd0);
        chk("rst_req_idle", 32'(in_ready), 32'd1);

        // Reset while waiting for the response, then a stale response
        start_load(32'h8000_0044);
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk("wait_req_low", 32'(req_valid), 32'd0);
        chk("wait_in_ready", 32'(in_ready), 32'd0);
        pulse_rst;
        chk("rstw_req_valid", 32'(req_valid), 32'd0);
        chk("rstw_out_valid", 32'(out_valid), 32'd0);
        chk("rstw_in_ready", 32'(in_ready), 32'd1);
        resp_valid = 1'b1;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        chk("stale_out_valid", 32'(out_valid), 32'd0);
        chk("stale_in_ready", 32'(in_ready), 32'd1);
        chk("stale_out_data", out_data, 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 4))
                0, 1:    op = OP_LOAD;
                2:       op = OP_STORE;
                3:       op = 7'b0010011;
                default: op = 7'b0110011;
            endcase
            v = model(op, 3'($urandom_range(0, 7)), 32'h8000_0000 | ($urandom & 32'h0000_FFFF),
                      $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            v.rs = $urandom_range(0, 3);
            v.rdl = $urandom_range(0, 3);
            v.os = $urandom_range(0, 2);
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_25040109_lsu.md
Name: ysyx_25040109_lsu

Overview:
Load/store unit directly downstream of the execute stage in the NPC core.
- Consumes the execute result (effective address or plain ALU result), rs2 data, opcode, funct3, rd and the write-enable.
- Performs load/store through a word-wide memory port with valid/ready handshakes.
- Aligns and extends load data, then presents writeback data to the WBU over a valid/ready interface.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 for RV32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EXU has an instruction.
- in_ready  out  1  LSU can accept; high only in IDLE.
- in_opcode  in  7  instruction opcode.
- in_funct3  in  3  access size/sign.
- in_result  in  32  EXU result; this is the effective address for loads/stores.
- in_rs2  in  32  store data.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable from EXU.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- req_wen  out  1  1 = store.
- req_wdata  out  32  lane-shifted store data.
- req_wstrb  out  4  byte strobes; 0 for loads.
- resp_valid  in  1  read data / write ack; always accepted in WAIT.
- resp_rdata  in  32  raw word read.
- out_valid  out  1  writeback data valid.
- out_ready  in  1  WBU accepts.
- out_data  out  32  writeback value.
- out_rd  out  5  destination register.
- out_wen  out  1  register write enable; forced 0 for stores and on error.
- out_err  out  1  misaligned access or illegal funct3.

Behaviour:
- Reset values: in_ready=1, req_valid=0, req_wen=0, req_wstrb=0, req_addr=0, req_wdata=0, out_valid=0, out_data=0, out_rd=0, out_wen=0, out_err=0, state=IDLE.
- Reset mid-operation returns to IDLE the next cycle and drops req_valid. A resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - The handshake in_valid&&in_ready latches all inputs.
  - Memory op (opcode 0000011 or 0100011) with a legal, aligned access -> REQ.
  - Any other opcode, or an error -> DONE.
- REQ: req_valid=1 with stable req_* fields until req_ready. On handshake -> WAIT.
- WAIT: on resp_valid -> DONE.
  - Loads register the extracted data.
  - Stores register out_data=0.
- DONE: out_valid=1 and outputs held stable until out_ready -> IDLE. The next instruction can be accepted no earlier than the cycle after the out handshake.
- Pass-through: out_data=in_result, out_wen=in_wen. Latency is 1 cycle from accept to out_valid.
- Minimum memory latency: accept at N, req_valid at N+1.
  - With req_ready=1 and resp_valid at N+2, out_valid rises at N+3.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else sets out_err=1.
- Alignment (off=addr[1:0]):
  - Halfword requires off[0]=0; word requires off=0.
  - A violation sets out_err=1, out_wen=0, out_data=0, and issues no memory request.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<off.
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<off.
  - SW: wdata=rs2, wstrb=4'b1111.
- Loads shift rdata right by 8*off:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW uses the word unchanged.
- out_wen=in_wen for loads; 0 for stores.
- in_valid deasserting without a handshake has no effect.
- out_ready held low stalls in DONE indefinitely with outputs unchanged.

Test Plan:
- Pass-through: ADDI opcode 0010011, in_result=0x0000_1234, rd=5, wen=1, out_ready=1 -> out_valid one cycle after accept, out_data=0x1234, out_rd=5, out_wen=1, req_valid never asserted.
- LB sign: addr=0x8000_0003, resp_rdata=0x80FF_7F01 -> req_addr=0x8000_0000, wstrb=0, out_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH: addr=0x8000_0102, rs2=0xDEAD_BEEF -> req_wen=1, req_addr=0x8000_0100, wstrb=4'b1100, wdata=0xBEEF_BEEF, out_wen=0.
- Misaligned LW: addr=0x8000_0001 -> no req_valid, out_err=1, out_wen=0, out_data=0 one cycle after accept.
- Backpressure: req_ready low 3 cycles, then resp_valid 2 cycles later, then out_ready low 2 cycles -> req fields stable throughout, in_ready=0 until the out handshake, exactly one out transfer.
- Reset in WAIT: assert rst for 1 cycle, then pulse resp_valid -> req_valid=0, out_valid=0, state IDLE, stale resp ignored, in_ready=1.
